rb_commit_unit: RTL and testbench

In-order retirement stage for the reorder buffer (RB). Functional units deliver results into per-slot CDB registers, indexed by RB slot. This block consumes those registers:
- allocates slots in program order;
- waits for the head slot's valid bit;
- retires the head either as a register-file write or as a memory store (with request/acknowledge handshake);
- pulses a per-slot clear mask so the CDB side can zero the retired slot's valid bit.

---
 rtl/rb_commit_unit_if.sv | 41 ++++
 rtl/rb_commit_unit.sv | 114 +++++++++++
 tb/tb_rb_commit_unit.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rb_commit_unit_if.sv
// Bundle of dispatch, CDB, register-write and store-port signals seen by the RB commit unit.
// The commit unit takes the slave side; dispatch, CDB and memory act as the master.
interface rb_commit_unit_if #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5
);
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data;
  logic [RB_SIZE-1:0]           CDB_data_valid;
  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_addr;
  logic                         alloc_valid;
  logic                         alloc_is_store;
  logic [REG_INDEX-1:0]         alloc_dest;
  logic                         alloc_ready;
  logic [RB_INDEX-1:0]          alloc_index;
  logic                         rf_we;
  logic [REG_INDEX-1:0]         rf_waddr;
  logic [WORD_SIZE-1:0]         rf_wdata;
  logic                         mem_req;
  logic [WORD_SIZE-1:0]         mem_addr;
  logic [WORD_SIZE-1:0]         mem_wdata;
  logic                         mem_ack;
  logic [RB_SIZE-1:0]           clear_mask;

  modport slave (
    input  CDB_data_data, CDB_data_valid, CDB_data_addr,
    input  alloc_valid, alloc_is_store, alloc_dest, mem_ack,
    output alloc_ready, alloc_index,
    output rf_we, rf_waddr, rf_wdata,
    output mem_req, mem_addr, mem_wdata, clear_mask
  );

  modport master (
    output CDB_data_data, CDB_data_valid, CDB_data_addr,
    output alloc_valid, alloc_is_store, alloc_dest, mem_ack,
    input  alloc_ready, alloc_index,
    input  rf_we, rf_waddr, rf_wdata,
    input  mem_req, mem_addr, mem_wdata, clear_mask
  );
endinterface

// File: rtl/rb_commit_unit.sv
// In-order retirement stage of the reorder buffer: allocates slots in program order and
// retires the head slot either as a register write or as a handshaked memory store.
module rb_commit_unit #(
  parameter int WORD_SIZE = 32,
  parameter int RB_SIZE   = 8,
  parameter int RB_INDEX  = 3,
  parameter int REG_INDEX = 5
) (
  input logic           clk,
  input logic           reset,
  rb_commit_unit_if.slave bus
);

  typedef enum logic {IDLE, STORE_WAIT} state_t;

  localparam logic [RB_INDEX:0]   FULL_COUNT = (RB_INDEX+1)'(RB_SIZE);
  localparam logic [RB_INDEX:0]   CNT_ONE    = (RB_INDEX+1)'(1);
  localparam logic [RB_INDEX-1:0] LAST_SLOT  = RB_INDEX'(RB_SIZE-1);
  localparam logic [RB_INDEX-1:0] PTR_ONE    = RB_INDEX'(1);
  localparam logic [RB_SIZE-1:0]  MASK_ONE   = RB_SIZE'(1);

  state_t               state;
  logic [RB_INDEX-1:0]  head;
  logic [RB_INDEX-1:0]  tail;
  logic [RB_INDEX:0]    count;
  logic [RB_SIZE-1:0]   is_store;
  logic [REG_INDEX-1:0] dest [RB_SIZE];

  logic                 alloc_fire;
  logic                 head_ready;
  logic                 retire_reg;
  logic                 start_store;
  logic                 store_done;
  logic                 retire;
  logic [WORD_SIZE-1:0] head_data;
  logic [WORD_SIZE-1:0] head_addr;

  function automatic logic [RB_INDEX-1:0] next_ptr(input logic [RB_INDEX-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + PTR_ONE;
  endfunction

  // alloc_ready looks at the pre-update count, so a full RB refuses even while retiring
  assign bus.alloc_ready = (count != FULL_COUNT);
  assign bus.alloc_index = tail;

  // An empty RB ignores whatever stale valid bit sits at head
  assign alloc_fire  = bus.alloc_valid && bus.alloc_ready;
  assign head_ready  = (count != '0) && bus.CDB_data_valid[head];
  assign retire_reg  = (state == IDLE) && head_ready && !is_store[head];
  assign start_store = (state == IDLE) && head_ready && is_store[head];
  assign store_done  = (state == STORE_WAIT) && bus.mem_ack;
  assign retire      = retire_reg || store_done;
  assign head_data   = bus.CDB_data_data[int'(head)*WORD_SIZE +: WORD_SIZE];
  assign head_addr   = bus.CDB_data_addr[int'(head)*WORD_SIZE +: WORD_SIZE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      is_store       <= '0;
      for (int i = 0; i < RB_SIZE; i++) dest[i] <= '0;
      bus.rf_we      <= 1'b0;
      bus.rf_waddr   <= '0;
      bus.rf_wdata   <= '0;
      bus.mem_req    <= 1'b0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
      bus.clear_mask <= '0;
    end else begin
      // Writes to r0 are suppressed but the slot still retires and is cleared
      bus.rf_we      <= retire_reg && (dest[head] != '0);
      bus.clear_mask <= retire ? (MASK_ONE << head) : '0;
      if (retire_reg) begin
        bus.rf_waddr <= dest[head];
        bus.rf_wdata <= head_data;
      end

      if (alloc_fire) begin
        is_store[tail] <= bus.alloc_is_store;
        dest[tail]     <= bus.alloc_dest;
        tail           <= next_ptr(tail);
      end
      if (retire) head <= next_ptr(head);

      case ({alloc_fire, retire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // A store keeps head in place until the memory side acknowledges it
      case (state)
        IDLE: begin
          if (start_store) begin
            bus.mem_req   <= 1'b1;
            bus.mem_addr  <= head_addr;
            bus.mem_wdata <= head_data;
            state         <= STORE_WAIT;
          end
        end
        STORE_WAIT: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rb_commit_unit.sv
// Directed self-checking bench for rb_commit_unit; the bench also plays the CDB side,
// dropping a slot's valid bit in the cycle its clear_mask pulse appears.
module tb_rb_commit_unit;
  localparam int WS = 32;
  localparam int RS = 8;
  localparam int RI = 3;
  localparam int GI = 5;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rb_commit_unit_if #(.WORD_SIZE(WS), .RB_SIZE(RS), .RB_INDEX(RI), .REG_INDEX(GI)) bus ();

  rb_commit_unit #(.WORD_SIZE(WS), .RB_SIZE(RS), .RB_INDEX(RI), .REG_INDEX(GI)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    bus.CDB_data_valid = bus.CDB_data_valid & ~bus.clear_mask;
  endtask

  task automatic set_slot(input int k, input logic [WS-1:0] data, input logic [WS-1:0] addr);
    bus.CDB_data_data[k*WS +: WS] = data;
    bus.CDB_data_addr[k*WS +: WS] = addr;
  endtask

  task automatic clear_inputs();
    bus.CDB_data_data  = '0;
    bus.CDB_data_addr  = '0;
    bus.CDB_data_valid = '0;
    bus.alloc_valid    = 1'b0;
    bus.alloc_is_store = 1'b0;
    bus.alloc_dest     = '0;
    bus.mem_ack        = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic alloc_one(input logic st, input logic [GI-1:0] d);
    bus.alloc_valid    = 1'b1;
    bus.alloc_is_store = st;
    bus.alloc_dest     = d;
    step();
    bus.alloc_valid    = 1'b0;
    bus.alloc_is_store = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    #12;
    n_checks++;
    if ({bus.rf_we, bus.mem_req, bus.clear_mask} !== 10'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_strobes: got we=%0b req=%0b clr=%02h expected 0 0 00", bus.rf_we, bus.mem_req, bus.clear_mask);
    end
    n_checks++;
    if ({bus.rf_waddr, bus.rf_wdata, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got waddr=%0d wdata=%08h maddr=%08h mdata=%08h expected all 0", bus.rf_waddr, bus.rf_wdata, bus.mem_addr, bus.mem_wdata);
    end
    n_checks++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_index !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_alloc: got ready=%0b index=%0d expected 1 0", bus.alloc_ready, bus.alloc_index);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_in_order_reg();
    do_reset();
    set_slot(0, 32'h1111_0001, '0);
    set_slot(1, 32'h1111_0002, '0);
    set_slot(2, 32'h1111_0003, '0);
    alloc_one(1'b0, 5'd1);
    alloc_one(1'b0, 5'd2);
    alloc_one(1'b0, 5'd3);
    n_checks++;
    if (bus.alloc_index !== 3'd3) begin
      n_fail++;
      $display("[TB] FAIL reg_tail: got %0d expected 3", bus.alloc_index);
    end
    bus.CDB_data_valid[2] = 1'b1;
    step();
    n_checks++;
    if (bus.rf_we !== 1'b0 || bus.clear_mask !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reg_out_of_order: got we=%0b clr=%02h expected 0 00", bus.rf_we, bus.clear_mask);
    end
    bus.CDB_data_valid[0] = 1'b1;
    step();
    n_checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'h1111_0001 || bus.clear_mask !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL reg_r1: got we=%0b waddr=%0d wdata=%08h clr=%02h expected 1 1 11110001 01", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.clear_mask);
    end
    bus.CDB_data_valid[1] = 1'b1;
    step();
    n_checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd2 || bus.rf_wdata !== 32'h1111_0002 || bus.clear_mask !== 8'h02) begin
      n_fail++;
      $display("[TB] FAIL reg_r2: got we=%0b waddr=%0d wdata=%08h clr=%02h expected 1 2 11110002 02", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.clear_mask);
    end
    step();
    n_checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'h1111_0003 || bus.clear_mask !== 8'h04) begin
      n_fail++;
      $display("[TB] FAIL reg_r3: got we=%0b waddr=%0d wdata=%08h clr=%02h expected 1 3 11110003 04", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.clear_mask);
    end
    step();
    n_checks++;
    if (bus.rf_we !== 1'b0 || bus.clear_mask !== 8'h00 || dut.count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reg_drained: got we=%0b clr=%02h count=%0d expected 0 00 0", bus.rf_we, bus.clear_mask, dut.count);
    end
  endtask

  task automatic test_store();
    do_reset();
    set_slot(0, 32'h0000_DEAD, 32'h0000_0100);
    alloc_one(1'b1, 5'd7);
    bus.CDB_data_valid[0] = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEAD || bus.clear_mask !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL store_wait_%0d: got req=%0b addr=%08h data=%08h clr=%02h expected 1 00000100 0000dead 00", c, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.clear_mask);
      end
      if (c == 3) bus.mem_ack = 1'b1;
      step();
    end
    bus.mem_ack = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.clear_mask !== 8'h01 || bus.rf_we !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL store_ack: got req=%0b clr=%02h we=%0b expected 0 01 0", bus.mem_req, bus.clear_mask, bus.rf_we);
    end
    bus.mem_ack = 1'b1;
    step();
    bus.mem_ack = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.clear_mask !== 8'h00 || dut.count !== 4'd0 || bus.alloc_index !== 3'd1) begin
      n_fail++;
      $display("[TB] FAIL store_done: got req=%0b clr=%02h count=%0d index=%0d expected 0 00 0 1", bus.mem_req, bus.clear_mask, dut.count, bus.alloc_index);
    end
  endtask

  task automatic test_full_wrap();
    int q[$];
    int m_head;
    int m_tail;
    int m_count;
    int next_dest;
    int allocated;
    do_reset();
    bus.alloc_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.alloc_dest = 5'(k + 1);
      set_slot(k, 32'hA000 + 32'(k + 1), '0);
      step();
    end
    n_checks++;
    if (bus.alloc_ready !== 1'b0 || bus.alloc_index !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL full_ready: got ready=%0b index=%0d expected 0 0", bus.alloc_ready, bus.alloc_index);
    end
    bus.alloc_dest = 5'd31;
    step();
    n_checks++;
    if (bus.alloc_index !== 3'd0 || dut.count !== 4'd8) begin
      n_fail++;
      $display("[TB] FAIL full_ninth_ignored: got index=%0d count=%0d expected 0 8", bus.alloc_index, dut.count);
    end
    bus.CDB_data_valid[0] = 1'b1;
    step();
    n_checks++;
    if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'hA001 || bus.alloc_ready !== 1'b1 || bus.alloc_index !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL full_retire: got we=%0b waddr=%0d wdata=%08h ready=%0b index=%0d expected 1 1 0000a001 1 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.alloc_ready, bus.alloc_index);
    end
    set_slot(0, 32'hA009, '0);
    bus.alloc_dest = 5'd9;
    step();
    bus.alloc_valid = 1'b0;
    n_checks++;
    if (bus.alloc_index !== 3'd1 || bus.alloc_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL full_realloc: got index=%0d ready=%0b expected 1 0", bus.alloc_index, bus.alloc_ready);
    end

    // Stream 20 more entries through while retiring one per cycle; head wraps repeatedly
    q = '{2, 3, 4, 5, 6, 7, 8, 9};
    m_head = 1;
    m_tail = 1;
    m_count = 8;
    next_dest = 10;
    allocated = 0;
    bus.CDB_data_valid = 8'hFF;
    for (int it = 0; it < 100 && (allocated < 20 || q.size() > 0); it++) begin
      logic will_alloc;
      logic will_retire;
      will_retire = (m_count > 0);
      will_alloc = 1'b0;
      n_checks++;
      if (bus.alloc_ready !== (m_count != 8) || bus.alloc_index !== 3'(m_tail)) begin
        n_fail++;
        $display("[TB] FAIL wrap_alloc_it%0d: got ready=%0b index=%0d expected %0b %0d", it, bus.alloc_ready, bus.alloc_index, (m_count != 8), m_tail);
      end
      if (allocated < 20) begin
        bus.alloc_valid = 1'b1;
        bus.alloc_dest  = 5'(next_dest);
        will_alloc = (m_count != 8);
        if (will_alloc) begin
          set_slot(m_tail, 32'hA000 + 32'(next_dest), '0);
          bus.CDB_data_valid[m_tail] = 1'b1;
        end
      end else begin
        bus.alloc_valid = 1'b0;
      end
      step();
      if (will_retire) begin
        n_checks++;
        if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'(q[0]) || bus.rf_wdata !== 32'hA000 + 32'(q[0]) || bus.clear_mask !== 8'(1) << m_head) begin
          n_fail++;
          $display("[TB] FAIL wrap_retire_it%0d: got we=%0b waddr=%0d wdata=%08h clr=%02h expected 1 %0d %08h %02h", it, bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.clear_mask, q[0], 32'hA000 + 32'(q[0]), 8'(1) << m_head);
        end
        void'(q.pop_front());
        m_head = (m_head + 1) % 8;
      end else begin
        n_checks++;
        if (bus.rf_we !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL wrap_idle_it%0d: got we=%0b expected 0", it, bus.rf_we);
        end
      end
      if (will_alloc) begin
        q.push_back(next_dest);
        m_tail = (m_tail + 1) % 8;
        next_dest++;
        allocated++;
      end
      m_count = m_count + int'(will_alloc) - int'(will_retire);
    end
    bus.alloc_valid = 1'b0;
    n_checks++;
    if (dut.count !== 4'd0 || bus.alloc_index !== 3'd5 || bus.alloc_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL wrap_end: got count=%0d index=%0d ready=%0b expected 0 5 1", dut.count, bus.alloc_index, bus.alloc_ready);
    end
  endtask

  task automatic test_r0_dest();
    do_reset();
    set_slot(0, 32'h55, '0);
    bus.CDB_data_valid[0] = 1'b1;
    alloc_one(1'b0, 5'd0);
    n_checks++;
    if (bus.rf_we !== 1'b0 || bus.clear_mask !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL r0_empty_ignored: got we=%0b clr=%02h expected 0 00", bus.rf_we, bus.clear_mask);
    end
    step();
    n_checks++;
    if (bus.rf_we !== 1'b0 || bus.clear_mask !== 8'h01 || dut.count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL r0_retire: got we=%0b clr=%02h count=%0d expected 0 01 0", bus.rf_we, bus.clear_mask, dut.count);
    end
    bus.CDB_data_valid[1] = 1'b1;
    step();
    n_checks++;
    if (bus.clear_mask !== 8'h00 || bus.rf_we !== 1'b0 || dut.count !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL r0_stale_valid: got clr=%02h we=%0b count=%0d expected 00 0 0", bus.clear_mask, bus.rf_we, dut.count);
    end
    bus.CDB_data_valid[1] = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    set_slot(0, 32'hBEEF, 32'h200);
    alloc_one(1'b1, 5'd0);
    bus.CDB_data_valid[0] = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200) begin
      n_fail++;
      $display("[TB] FAIL areset_pre: got req=%0b addr=%08h expected 1 00000200", bus.mem_req, bus.mem_addr);
    end
    #3;
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL areset_immediate: got req=%0b addr=%08h data=%08h expected 0 0 0", bus.mem_req, bus.mem_addr, bus.mem_wdata);
    end
    bus.CDB_data_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    step();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.clear_mask !== 8'h00 || bus.rf_we !== 1'b0 || dut.count !== 4'd0 || bus.alloc_index !== 3'd0) begin
      n_fail++;
      $display("[TB] FAIL areset_after: got req=%0b clr=%02h we=%0b count=%0d index=%0d expected 0 00 0 0 0", bus.mem_req, bus.clear_mask, bus.rf_we, dut.count, bus.alloc_index);
    end
  endtask

  initial begin
    test_reset();
    test_in_order_reg();
    test_store();
    test_full_wrap();
    test_r0_dest();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
